// File: rtl/gun_pkg.sv
// Shared types for the light-gun shot sequencer: FSM state encoding and
// frame counter width.
package gun_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    BLACK,
    TARGET,
    RESULT,
    COOLDOWN
  } gun_state_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/ctl_gun_flash.sv
// Light-gun shot sequencer: trigger rise -> black frame(s) -> target frame(s)
// -> hit/miss pulse -> cooldown. All outputs are registered.
module ctl_gun_flash
  import gun_pkg::*;
#(
  parameter int BLACK_FRAMES    = 1,
  parameter int TARGET_FRAMES   = 1,
  parameter int COOLDOWN_FRAMES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic new_frame,
  input  logic enable,
  input  logic gun_is_connected,
  input  logic gun_trigger,
  input  logic gun_photodetector,
  output logic shot_fired,
  output logic hit,
  output logic miss,
  output logic blank_screen,
  output logic show_target,
  output logic busy
);

  localparam logic [CNT_W-1:0] BLACK_LAST  = CNT_W'(BLACK_FRAMES - 1);
  localparam logic [CNT_W-1:0] TARGET_LAST = CNT_W'(TARGET_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST   = CNT_W'(COOLDOWN_FRAMES);

  gun_state_t       state_reg, state_next;
  logic [CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic             trig_q_reg;
  logic             dark_fail_reg, dark_fail_next;
  logic             seen_reg, seen_next;
  logic             shot_next, hit_next, miss_next;
  logic             blank_next, show_next, busy_next;
  logic             rise;

  assign rise = gun_trigger & ~trig_q_reg;

  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    dark_fail_next = dark_fail_reg;
    seen_next      = seen_reg;
    shot_next      = 1'b0;
    hit_next       = 1'b0;
    miss_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (rise && enable && gun_is_connected) begin
          state_next = ARM;
          shot_next  = 1'b1;
        end
      end
      ARM: begin
        if (!gun_is_connected) begin
          state_next = IDLE;
          miss_next  = 1'b1;
        end else if (new_frame) begin
          state_next     = BLACK;
          frame_cnt_next = '0;
          dark_fail_next = 1'b0;
          seen_next      = 1'b0;
        end
      end
      BLACK: begin
        if (!gun_is_connected) begin
          state_next = IDLE;
          miss_next  = 1'b1;
        end else begin
          dark_fail_next = dark_fail_reg | gun_photodetector;
          if (new_frame) begin
            if (frame_cnt_reg == BLACK_LAST) begin
              state_next     = TARGET;
              frame_cnt_next = '0;
            end else begin
              frame_cnt_next = frame_cnt_reg + 1'b1;
            end
          end
        end
      end
      TARGET: begin
        if (!gun_is_connected) begin
          state_next = IDLE;
          miss_next  = 1'b1;
        end else begin
          seen_next = seen_reg | gun_photodetector;
          if (new_frame) begin
            if (frame_cnt_reg == TARGET_LAST) begin
              // The result pulse is registered on entry so it is visible
              // during the single RESULT cycle.
              state_next = RESULT;
              hit_next   = seen_next & ~dark_fail_reg;
              miss_next  = ~(seen_next & ~dark_fail_reg);
            end else begin
              frame_cnt_next = frame_cnt_reg + 1'b1;
            end
          end
        end
      end
      RESULT: begin
        state_next     = COOLDOWN;
        frame_cnt_next = '0;
      end
      COOLDOWN: begin
        if (frame_cnt_reg == COOL_LAST) begin
          state_next = IDLE;
        end else if (new_frame) begin
          frame_cnt_next = frame_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    blank_next = (state_next == BLACK) || (state_next == TARGET);
    show_next  = (state_next == TARGET);
    busy_next  = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      frame_cnt_reg <= '0;
      trig_q_reg    <= 1'b0;
      dark_fail_reg <= 1'b0;
      seen_reg      <= 1'b0;
      shot_fired    <= 1'b0;
      hit           <= 1'b0;
      miss          <= 1'b0;
      blank_screen  <= 1'b0;
      show_target   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_reg     <= state_next;
      frame_cnt_reg <= frame_cnt_next;
      trig_q_reg    <= gun_trigger;
      dark_fail_reg <= dark_fail_next;
      seen_reg      <= seen_next;
      shot_fired    <= shot_next;
      hit           <= hit_next;
      miss          <= miss_next;
      blank_screen  <= blank_next;
      show_target   <= show_next;
      busy          <= busy_next;
    end
  end

endmodule

// File: tb/tb_ctl_gun_flash.sv
// Directed self-checking bench for ctl_gun_flash with default parameters and
// a short synthetic frame period.
module tb_ctl_gun_flash;

  localparam int FRAME = 300;

  logic clk = 1'b0;
  logic rst, new_frame, enable, gun_is_connected, gun_trigger, gun_photodetector;
  logic shot_fired, hit, miss, blank_screen, show_target, busy;

  int checks = 0;
  int errors = 0;
  int n_shot = 0, n_hit = 0, n_miss = 0, n_blank = 0, n_show = 0, n_overlap = 0;

  always #5 clk = ~clk;

  ctl_gun_flash #(
    .BLACK_FRAMES(1),
    .TARGET_FRAMES(1),
    .COOLDOWN_FRAMES(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .new_frame(new_frame),
    .enable(enable),
    .gun_is_connected(gun_is_connected),
    .gun_trigger(gun_trigger),
    .gun_photodetector(gun_photodetector),
    .shot_fired(shot_fired),
    .hit(hit),
    .miss(miss),
    .blank_screen(blank_screen),
    .show_target(show_target),
    .busy(busy)
  );

  always @(negedge clk) begin
    if (shot_fired) n_shot <= n_shot + 1;
    if (hit) n_hit <= n_hit + 1;
    if (miss) n_miss <= n_miss + 1;
    if (blank_screen) n_blank <= n_blank + 1;
    if (show_target) n_show <= n_show + 1;
    if (int'(shot_fired) + int'(hit) + int'(miss) > 1) n_overlap <= n_overlap + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int ph_start, input int ph_len, input int rise_at);
    for (int i = 0; i < FRAME; i++) begin
      new_frame = (i == 0);
      gun_photodetector = (i >= ph_start) && (i < ph_start + ph_len);
      if (rise_at >= 0 && i == rise_at) gun_trigger = 1'b1;
      if (rise_at >= 0 && i == rise_at + 5) gun_trigger = 1'b0;
      tick();
    end
    new_frame = 1'b0;
    gun_photodetector = 1'b0;
  endtask

  // One full shot from trigger rise through the RESULT cycle.
  task automatic shot_seq(input string name, input bit ph_black, input bit ph_target,
                          input bit exp_hit, input bit hold);
    int s0, b0, t0;
    s0 = n_shot; b0 = n_blank; t0 = n_show;
    gun_trigger = 1'b0;
    tick();
    gun_trigger = 1'b1;
    tick();
    checks++;
    if (shot_fired !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s shot_accept: shot_fired=%b busy=%b required 1 1", name, shot_fired, busy);
    end
    if (!hold) gun_trigger = 1'b0;
    run_frame(ph_black ? 50 : 0, ph_black ? 200 : 0, -1);
    checks++;
    if (blank_screen !== 1'b1 || show_target !== 1'b0) begin
      errors++;
      $display("FAIL %s black_frame: blank=%b show=%b required 1 0", name, blank_screen, show_target);
    end
    run_frame(ph_target ? 50 : 0, ph_target ? 200 : 0, -1);
    checks++;
    if (blank_screen !== 1'b1 || show_target !== 1'b1) begin
      errors++;
      $display("FAIL %s target_frame: blank=%b show=%b required 1 1", name, blank_screen, show_target);
    end
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    checks++;
    if (hit !== exp_hit || miss !== !exp_hit || blank_screen !== 1'b0 ||
        show_target !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s result: hit=%b miss=%b blank=%b show=%b busy=%b required %b %b 0 0 1",
               name, hit, miss, blank_screen, show_target, busy, exp_hit, !exp_hit);
    end
    tick();
    checks++;
    if (hit !== 1'b0 || miss !== 1'b0) begin
      errors++;
      $display("FAIL %s result_pulse_width: hit=%b miss=%b required 0 0", name, hit, miss);
    end
    checks++;
    if (n_shot - s0 != 1 || n_blank - b0 != 2 * FRAME || n_show - t0 != FRAME) begin
      errors++;
      $display("FAIL %s counts: shots=%0d blank=%0d show=%0d required 1 %0d %0d",
               name, n_shot - s0, n_blank - b0, n_show - t0, 2 * FRAME, FRAME);
    end
    $display("shot %s: hit=%0d miss=%0d", name, n_hit, n_miss);
  endtask

  // Cooldown of 10 frames; busy must drop one cycle after the 10th new_frame.
  task automatic cooldown(input string name, input bit rise_inside);
    int s0;
    s0 = n_shot;
    for (int f = 0; f < 9; f++) run_frame(0, 0, (rise_inside && f == 3) ? 100 : -1);
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s cooldown_busy: busy=%b required 1", name, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s cooldown_end: busy=%b required 0", name, busy);
    end
    checks++;
    if (n_shot - s0 != 0) begin
      errors++;
      $display("FAIL %s cooldown_no_shot: shots=%0d required 0", name, n_shot - s0);
    end
    $display("cooldown %s done", name);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    enable = 1'b1;
    gun_is_connected = 1'b1;
    gun_trigger = 1'b0;
    gun_photodetector = 1'b0;
    new_frame = 1'b0;
    repeat (3) tick();
    checks++;
    if ({shot_fired, hit, miss, blank_screen, show_target, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 000000",
               {shot_fired, hit, miss, blank_screen, show_target, busy});
    end
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b required 0", busy);
    end
    $display("reset done");
  endtask

  task automatic test_hit();
    shot_seq("hit", 1'b0, 1'b1, 1'b1, 1'b0);
    cooldown("hit", 1'b0);
  endtask

  task automatic test_dark_fail();
    shot_seq("dark_fail", 1'b1, 1'b1, 1'b0, 1'b0);
    cooldown("dark_fail", 1'b0);
  endtask

  task automatic test_no_photo();
    shot_seq("no_photo", 1'b0, 1'b0, 1'b0, 1'b0);
    cooldown("no_photo", 1'b1);
    shot_seq("after_cooldown", 1'b0, 1'b1, 1'b1, 1'b0);
    cooldown("after_cooldown", 1'b0);
  endtask

  task automatic test_trigger_held();
    int s0;
    shot_seq("held", 1'b0, 1'b1, 1'b1, 1'b1);
    cooldown("held", 1'b0);
    s0 = n_shot;
    repeat (20) tick();
    checks++;
    if (n_shot - s0 != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL held_no_refire: shots=%0d busy=%b required 0 0", n_shot - s0, busy);
    end
    shot_seq("repress", 1'b0, 1'b0, 1'b0, 1'b0);
    cooldown("repress", 1'b0);
  endtask

  task automatic test_abort_enable();
    int s0, m0;
    s0 = n_shot; m0 = n_miss;
    gun_trigger = 1'b0;
    tick();
    gun_trigger = 1'b1;
    tick();
    gun_trigger = 1'b0;
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    repeat (5) tick();
    checks++;
    if (blank_screen !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre_blank: blank=%b required 1", blank_screen);
    end
    gun_is_connected = 1'b0;
    tick();
    checks++;
    if (blank_screen !== 1'b0 || miss !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort: blank=%b miss=%b busy=%b required 0 1 0", blank_screen, miss, busy);
    end
    tick();
    checks++;
    if (miss !== 1'b0 || n_miss - m0 != 1 || n_shot - s0 != 1) begin
      errors++;
      $display("FAIL abort_once: miss=%b misses=%0d shots=%0d required 0 1 1",
               miss, n_miss - m0, n_shot - s0);
    end
    gun_is_connected = 1'b1;
    $display("abort done");
    enable = 1'b0;
    s0 = n_shot;
    tick();
    gun_trigger = 1'b1;
    tick();
    gun_trigger = 1'b0;
    repeat (5) tick();
    checks++;
    if (n_shot - s0 != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL enable_gate: shots=%0d busy=%b required 0 0", n_shot - s0, busy);
    end
    enable = 1'b1;
    $display("enable gate done");
  endtask

  task automatic test_reset_mid_target();
    int h0, m0;
    gun_trigger = 1'b0;
    tick();
    gun_trigger = 1'b1;
    tick();
    gun_trigger = 1'b0;
    run_frame(0, 0, -1);
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    repeat (10) tick();
    checks++;
    if (show_target !== 1'b1) begin
      errors++;
      $display("FAIL mid_target_setup: show=%b required 1", show_target);
    end
    h0 = n_hit; m0 = n_miss;
    rst = 1'b0;
    #1;
    checks++;
    if ({shot_fired, hit, miss, blank_screen, show_target, busy} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: got %b required 000000",
               {shot_fired, hit, miss, blank_screen, show_target, busy});
    end
    repeat (3) tick();
    rst = 1'b1;
    run_frame(0, 0, -1);
    run_frame(0, 0, -1);
    checks++;
    if (n_hit - h0 != 0 || n_miss - m0 != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_result: hits=%0d misses=%0d busy=%b required 0 0 0",
               n_hit - h0, n_miss - m0, busy);
    end
    $display("reset mid-target done");
  endtask

  initial begin
    test_reset();
    test_hit();
    test_dark_fail();
    test_no_photo();
    test_trigger_held();
    test_abort_enable();
    test_reset_mid_target();
    checks++;
    if (n_overlap != 0) begin
      errors++;
      $display("FAIL pulse_exclusive: overlap_cycles=%0d required 0", n_overlap);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctl_gun_flash.md
Name: ctl_gun_flash

Overview:
Light-gun shot sequencer between the debounced gun inputs and the score/ammo and draw stages. On a trigger press it issues a shot and blanks the screen for BLACK_FRAMES frames. It then shows white target boxes for TARGET_FRAMES frames while sampling the photodetector, and reports hit or miss. It drives the blanking and target-show controls consumed by draw_target and draw_overlay, and hit/miss/shot_fired consumed by ctl_score and ctl_ammo.

Parameters:
BLACK_FRAMES, 1, frames of black screen before the target frame(s), range 1..255
TARGET_FRAMES, 1, frames with white target boxes shown, range 1..255
COOLDOWN_FRAMES, 10, frames after a result during which triggers are ignored, range 0..255

Ports:
clk  in  1  65 MHz system clock
rst  in  1  asynchronous reset, active-low
new_frame  in  1  one-cycle pulse at start of each VGA frame
enable  in  1  game running (low = pause/no ammo)
gun_is_connected  in  1  gun present
gun_trigger  in  1  debounced trigger level
gun_photodetector  in  1  debounced photodetector level
shot_fired  out  1  one-cycle pulse, shot accepted
hit  out  1  one-cycle pulse, target seen
miss  out  1  one-cycle pulse, target not seen or sequence aborted
blank_screen  out  1  level, draw whole screen black
show_target  out  1  level, draw white target box(es)
busy  out  1  level, sequence or cooldown in progress

Behaviour:
- All outputs registered. Reset (rst low, asynchronous) sets state IDLE, clears counters and flags, and drives all outputs to 0.
- Trigger edge: a registered previous-trigger bit gives rise = gun_trigger & ~trig_q. Only rises are accepted, so a held trigger never refires.
- States: IDLE, ARM, BLACK, TARGET, RESULT, COOLDOWN. busy=1 in every state except IDLE.
- IDLE: on rise & enable & gun_is_connected, pulse shot_fired on the next cycle and go to ARM. Otherwise stay.
- ARM: wait for new_frame. On new_frame go to BLACK, set frame_cnt=0, clear dark_fail and seen; blank_screen=1 from the next cycle.
- BLACK: blank_screen=1. gun_photodetector high on any cycle sets dark_fail (gun aimed at a light source). On new_frame: if frame_cnt==BLACK_FRAMES-1, go to TARGET and clear frame_cnt; else increment frame_cnt.
- TARGET: blank_screen=1, show_target=1. gun_photodetector high sets seen. On new_frame: if frame_cnt==TARGET_FRAMES-1, go to RESULT; else increment frame_cnt.
- RESULT (exactly 1 cycle): blank_screen=0, show_target=0. Pulse hit if seen & ~dark_fail, else pulse miss. Go to COOLDOWN with frame_cnt=0.
- COOLDOWN: count new_frame pulses. When frame_cnt==COOLDOWN_FRAMES, go to IDLE; with COOLDOWN_FRAMES=0 this is the next cycle. Rises during COOLDOWN are ignored and do not queue.
- Abort: gun_is_connected low in ARM/BLACK/TARGET causes the next state to be IDLE, drops blank_screen/show_target, and pulses miss once. Every shot_fired is therefore paired with exactly one hit or miss.
- enable falling mid-sequence does not abort; the sequence completes and reports. enable only gates new shots.
- new_frame coinciding with a rise in IDLE: the shot is accepted, and ARM waits for the following new_frame. The black frame is always a full frame.
- hit, miss and shot_fired are never asserted in the same cycle.
- Counter width: 8 bits, no wrap; comparisons use ==.
- Latency (defaults): rise at cycle t → shot_fired at t+1 → blank for 1 full frame + target 1 full frame → hit/miss 1 cycle after the second frame-boundary new_frame following ARM.

Decomposition:
- Package gun_pkg holds typedef enum logic [2:0] gun_state_t (IDLE, ARM, BLACK, TARGET, RESULT, COOLDOWN) and the 8-bit frame counter width constant.
- No sub-module needed. Edge detect and frame counter stay inline; a single always_ff plus one always_comb next-state block.

Test Plan:
- Reset mid-TARGET (rst low 3 cycles) → all outputs 0 within the same cycle rst is low; state IDLE; no hit/miss afterwards.
- Rise with enable=1, connected=1; photodetector pulsed high 200 cycles inside TARGET only → one shot_fired, blank_screen high 2 frames, show_target high 1 frame, exactly one hit pulse, busy high until 10 new_frames after RESULT.
- Same as above but photodetector high during BLACK and TARGET → one miss, no hit (dark_fail).
- Photodetector never high → one miss; a second rise during COOLDOWN → no shot_fired; rise after busy falls → new shot_fired.
- Trigger held high through whole sequence and cooldown → exactly one shot_fired; release then press → second shot_fired.
- gun_is_connected dropped during BLACK → blank_screen 0 next cycle, one miss pulse, state IDLE. Rise with enable=0 → no shot_fired, busy stays 0.
